// File: rtl/mat_sparvec_mul_sched.sv
// Round-robin scheduler sharing one mat_sparvec_mul engine among N_REQ requesters:
// grants a job, pulses start, waits for done, then streams the result words back.
module mat_sparvec_mul_sched #(
    parameter int unsigned N_REQ     = 2,
    parameter int unsigned RES_WORDS = 26,
    parameter int unsigned PROC_SIZE = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N_REQ-1:0]             i_req,
    output logic [N_REQ-1:0]             o_grant,
    output logic [$clog2(N_REQ)-1:0]     o_sel,
    output logic                         o_busy,
    output logic                         o_mul_start,
    input  logic                         i_mul_done,
    output logic                         o_res_en,
    output logic [$clog2(RES_WORDS)-1:0] o_res_addr,
    input  logic [PROC_SIZE-1:0]         i_res,
    output logic [PROC_SIZE-1:0]         o_res_data,
    output logic                         o_res_valid,
    output logic                         o_res_last,
    input  logic                         i_res_ready
);

    localparam int unsigned SelW  = $clog2(N_REQ);
    localparam int unsigned AddrW = $clog2(RES_WORDS);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StRun,
        StRdAddr,
        StRdWait,
        StRdOut
    } state_e;

    state_e               state_q, state_d;
    logic [SelW-1:0]      ptr_q, ptr_d;
    logic [AddrW-1:0]     cnt_q, cnt_d;
    logic [N_REQ-1:0]     grant_q, grant_d;
    logic [SelW-1:0]      sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic                 start_q, start_d;
    logic                 res_en_q, res_en_d;
    logic [PROC_SIZE-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;

    logic                 found;
    logic [SelW-1:0]      win;
    logic [SelW-1:0]      cand;

    function automatic logic [SelW-1:0] wrap_inc(logic [SelW-1:0] idx);
        return (int'(idx) == int'(N_REQ) - 1) ? '0 : idx + 1'b1;
    endfunction

    // Round-robin search starting at ptr_q.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = ptr_q;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (!found && i_req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        grant_d  = grant_q;
        sel_d    = sel_q;
        busy_d   = busy_q;
        start_d  = 1'b0;
        res_en_d = 1'b0;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;

        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StStart;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                end
            end
            StStart: state_d = StRun;
            StRun: begin
                if (i_mul_done) begin
                    state_d  = StRdAddr;
                    cnt_d    = '0;
                    res_en_d = 1'b1;
                end
            end
            StRdAddr: state_d = StRdWait;
            StRdWait: begin
                state_d = StRdOut;
                data_d  = i_res;
                valid_d = 1'b1;
                last_d  = (int'(cnt_q) == int'(RES_WORDS) - 1);
            end
            StRdOut: begin
                if (i_res_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (last_q) begin
                        state_d = StIdle;
                        grant_d = '0;
                        sel_d   = '0;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        ptr_d   = wrap_inc(sel_q);
                    end else begin
                        state_d  = StRdAddr;
                        cnt_d    = cnt_q + 1'b1;
                        res_en_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cnt_q    <= '0;
            grant_q  <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            res_en_q <= 1'b0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            grant_q  <= grant_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            res_en_q <= res_en_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    // The word counter doubles as the read address; it is only meaningful while o_res_en is high.
    assign o_grant     = grant_q;
    assign o_sel       = sel_q;
    assign o_busy      = busy_q;
    assign o_mul_start = start_q;
    assign o_res_en    = res_en_q;
    assign o_res_addr  = cnt_q;
    assign o_res_data  = data_q;
    assign o_res_valid = valid_q;
    assign o_res_last  = last_q;

endmodule
